fifo_sel_arb: RTL
=================

Name: fifo_sel_arb

Overview:
Parametrised successor to the fixed 12-port FIFO selector. It arbitrates among PORT_NUM FIFO request bits in either fixed-priority or round-robin mode. Each grant is locked until the downstream releases it, the requester drops, or an optional hold timeout expires. The block sits between the per-port FIFO status logic and the output scheduler, and keeps the codebase's 8-bit selection encoding (128+index when valid, 0 when idle).

Parameters:
PORT_NUM, 12, number of requesting FIFOs; legal range 2..128.
IDX_W, 4, width of the port index; must equal ceil(log2(PORT_NUM)).
MAX_HOLD, 0, maximum number of cycles a grant may be held; 0 means unlimited.

Ports:
glb_clk  input  1  single clock; all logic on rising edge.
glb_areset  input  1  asynchronous, active-high reset.
fifo_sel_bits  input  PORT_NUM  per-FIFO request; bit i high = FIFO i has data.
arb_mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin.
sel_release  input  1  one-cycle pulse from the consumer: current transfer done.
fifo_sel_res_final  output  8  registered; 128+sel_idx when sel_valid, else 0.
sel_valid  output  1  registered; a grant is active.
sel_idx  output  IDX_W  registered; index of the granted FIFO; 0 when idle.
sel_onehot  output  PORT_NUM  registered; one-hot grant; all zero when idle.
hold_cnt  output  16  registered; cycles the current grant has been held, saturating.

Behaviour:
- Reset (asynchronous, glb_areset=1):
  - All outputs go to 0.
  - State goes to IDLE.
  - Round-robin pointer rr_ptr goes to 0.
  - A reset asserted mid-grant drops the grant immediately; no release bookkeeping is kept.
- State machine, two states: IDLE and GRANT.
- Winner computation (combinational):
  - Fixed mode: lowest set index of fifo_sel_bits.
  - Round-robin mode: first set index at or above rr_ptr, wrapping modulo PORT_NUM.
  - No request: no winner.
- IDLE:
  - If any request bit is set at edge t, outputs show the winner at edge t+1 and state goes to GRANT. Latency is 1 cycle.
  - Otherwise stay in IDLE with outputs at 0.
- GRANT: the release event (rel) is the OR of three conditions:
  - sel_release=1;
  - fifo_sel_bits[sel_idx]=0 (requester dropped);
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (timeout).
- GRANT with rel=0:
  - The grant holds.
  - hold_cnt increments, saturating at 16'hFFFF.
  - Changes on other request bits are ignored.
- GRANT with rel=1:
  - rr_ptr <= (sel_idx+1) mod PORT_NUM, updated in both modes.
  - The winner is recomputed from the current fifo_sel_bits using the updated pointer, so regrant has no bubble.
  - If a winner exists: new grant at the next edge, hold_cnt=0, stay in GRANT.
  - If no winner: return to IDLE and all outputs go to 0 at the next edge.
  - In fixed mode the same port may win again if it is still requesting.
  - In round-robin mode the released port is the lowest priority for the next arbitration.
- arb_mode is sampled only at arbitration instants (IDLE with a request, or rel=1). Changing it mid-grant does not disturb the grant.
- sel_release while in IDLE is ignored.
- Output encoding: fifo_sel_res_final = sel_valid ? (8'd128 + sel_idx zero-extended) : 8'd0. All encodings are consistent with sel_onehot in every cycle.
- Invariant: at most one bit of sel_onehot is set; sel_valid equals the OR of sel_onehot.

Test Plan:
- Reset and idle:
  - Stimulus: assert glb_areset mid-simulation with a grant on port 5.
  - Required: all outputs 0 with no clock edge; after deassert with fifo_sel_bits=0, outputs stay 0.
- Fixed priority:
  - Stimulus: arb_mode=0, fifo_sel_bits=12'h0A0.
  - Required: next cycle fifo_sel_res_final=133 (port 5), sel_onehot=12'h020.
  - Stimulus: pulse sel_release with bits unchanged.
  - Required: port 5 is regranted the following cycle with hold_cnt=0.
- Round robin:
  - Stimulus: arb_mode=1, fifo_sel_bits=12'h811, sel_release pulsed every 3rd cycle.
  - Required: grant sequence ports 0, 4, 11, 0, with no idle cycle between grants.
- Requester drop:
  - Stimulus: grant on port 3, then clear bit 3 while bit 7 is set.
  - Required: the next edge grants port 7 (135).
  - Stimulus: clear all bits instead.
  - Required: outputs go to 0 and state returns to IDLE.
- Timeout:
  - Stimulus: MAX_HOLD=4, arb_mode=1, bits 12'h003, no sel_release.
  - Required: port 0 held for hold_cnt 0..3, then port 1 granted.
- Wide config:
  - Stimulus: PORT_NUM=100, IDX_W=7, only bit 99 set.
  - Required: fifo_sel_res_final=227, sel_idx=99.
  - Stimulus: round robin from rr_ptr=99 with bits 0 and 99 set after release of port 99.
  - Required: the pointer wraps and port 0 is granted.

Source files
------------

// File: rtl/fifo_sel_arb.sv
// Arbiter over PORT_NUM FIFO request bits, fixed-priority or round-robin.
// A grant is locked until the consumer releases it, the requester drops, or the hold timeout expires.
module fifo_sel_arb #(
    parameter int PORT_NUM = 12,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic                glb_clk,
    input  logic                glb_areset,
    input  logic [PORT_NUM-1:0] fifo_sel_bits,
    input  logic                arb_mode,
    input  logic                sel_release,
    output logic [7:0]          fifo_sel_res_final,
    output logic                sel_valid,
    output logic [IDX_W-1:0]    sel_idx,
    output logic [PORT_NUM-1:0] sel_onehot,
    output logic [15:0]         hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PORT_NUM - 1);
    localparam logic [IDX_W:0]   PORT_NUM_W = (IDX_W + 1)'(PORT_NUM);
    localparam logic [15:0]      HOLD_LIMIT = 16'(MAX_HOLD - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [15:0]           hold_q, hold_d;
    logic [PORT_NUM-1:0]   onehot_q, onehot_d;
    logic [7:0]            res_q, res_d;

    logic [IDX_W-1:0]      nxt_ptr;
    logic [IDX_W-1:0]      base;
    logic [PORT_NUM-1:0]   rot;
    logic [IDX_W-1:0]      rot_off;
    logic [IDX_W:0]        win_sum;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    logic                  rel;
    logic                  arb;

    assign nxt_ptr = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    assign rel = sel_release || !fifo_sel_bits[idx_q] ||
                 ((MAX_HOLD != 0) && (hold_q == HOLD_LIMIT));

    // On a release the search already starts past the released port, so regrant needs no bubble.
    assign base = arb_mode ? ((state_q == GRANT) ? nxt_ptr : rr_q) : '0;

    assign rot = PORT_NUM'({fifo_sel_bits, fifo_sel_bits} >> base);

    always_comb begin
        win_found = 1'b0;
        rot_off   = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            if (rot[IDX_W'(i)]) begin
                win_found = 1'b1;
                rot_off   = IDX_W'(i);
            end
        end
    end

    assign win_sum = {1'b0, base} + {1'b0, rot_off};
    assign win_idx = (win_sum >= PORT_NUM_W) ? IDX_W'(win_sum - PORT_NUM_W)
                                             : win_sum[IDX_W-1:0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        hold_d   = hold_q;
        arb      = 1'b0;
        onehot_d = '0;
        res_d    = 8'd0;

        case (state_q)
            IDLE: arb = |fifo_sel_bits;
            GRANT: begin
                if (rel) begin
                    arb  = 1'b1;
                    rr_d = nxt_ptr;
                end else if (hold_q != 16'hFFFF) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb) begin
            state_d = win_found ? GRANT : IDLE;
            idx_d   = win_found ? win_idx : '0;
            hold_d  = '0;
        end

        if (state_d == GRANT) begin
            onehot_d[idx_d] = 1'b1;
            res_d           = 8'd128 + 8'(idx_d);
        end
    end

    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_q     <= '0;
            hold_q   <= '0;
            onehot_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            hold_q   <= hold_d;
            onehot_q <= onehot_d;
            res_q    <= res_d;
        end
    end

    assign sel_valid          = (state_q == GRANT);
    assign sel_idx            = idx_q;
    assign sel_onehot         = onehot_q;
    assign hold_cnt           = hold_q;
    assign fifo_sel_res_final = res_q;

endmodule
